// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: default geometry and Gray/binary conversion,
// used by both the read and write pointer controllers.
package fifo_pkg;

    localparam int FIFO_DEPTH_BIT_DEF = 8;
    localparam int FIFO_WIDTH_BIT_DEF = 16;

    // Operate on 32-bit zero-extended values so any pointer width up to 32 fits.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO bus: consumer handshake, memory port B and cross-domain pointers.
// rd_almost_empty exists only when FIFO_RD_ALMOST_EMPTY_EN is defined.
interface fifo_rd_ctrl_if #(
    parameter int FIFO_DEPTH_Bit = fifo_pkg::FIFO_DEPTH_BIT_DEF,
    parameter int FIFO_WIDTH_Bit = fifo_pkg::FIFO_WIDTH_BIT_DEF
) ();

    logic                      rd_en;
    logic [FIFO_DEPTH_Bit:0]   wr_ptr_gray;
    logic [FIFO_WIDTH_Bit-1:0] mem_rd_data;
    logic [FIFO_DEPTH_Bit-1:0] rd_addr;
    logic [FIFO_DEPTH_Bit:0]   rd_ptr_gray;
    logic [FIFO_WIDTH_Bit-1:0] rd_data;
    logic                      rd_valid;
    logic                      rd_empty;
    logic [FIFO_DEPTH_Bit:0]   rd_level;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    logic                      rd_almost_empty;
`endif

    // master: consumer/memory/write-domain side; slave: the read controller
    modport master (
        output rd_en, wr_ptr_gray, mem_rd_data,
        input  rd_addr, rd_ptr_gray, rd_data, rd_valid, rd_empty, rd_level
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        , input rd_almost_empty
`endif
    );

    modport slave (
        input  rd_en, wr_ptr_gray, mem_rd_data,
        output rd_addr, rd_ptr_gray, rd_data, rd_valid, rd_empty, rd_level
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        , output rd_almost_empty
`endif
    );

endinterface

// File: rtl/fifo_sync2.sv
// Two-flop synchronizer for bringing a Gray-coded pointer into the local clock domain.
module fifo_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_wq1;
    logic [WIDTH-1:0] r_wq2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wq1 <= '0;
            r_wq2 <= '0;
        end else begin
            r_wq1 <= i_d;
            r_wq2 <= r_wq1;
        end
    end

    assign o_q = r_wq2;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async-FIFO read-pointer controller: pointer, empty flag and occupancy in the read domain.
// Optional rd_almost_empty output is built when FIFO_RD_ALMOST_EMPTY_EN is defined.
module fifo_rd_ctrl #(
    parameter int FIFO_DEPTH_Bit = fifo_pkg::FIFO_DEPTH_BIT_DEF,
    parameter int FIFO_WIDTH_Bit = fifo_pkg::FIFO_WIDTH_BIT_DEF,
    parameter int AE_THRESH      = 4
) (
    input logic           rd_clk,
    input logic           rd_rst_n,
    fifo_rd_ctrl_if.slave bus
);
    import fifo_pkg::*;

    localparam int PW = FIFO_DEPTH_Bit + 1;

    logic [PW-1:0]             w_wq2;
    logic                      w_accept;
    logic [PW-1:0]             w_next_bin;
    logic [PW-1:0]             w_next_gray;
    logic [PW-1:0]             w_next_level;
    logic [FIFO_WIDTH_Bit-1:0] w_rd_data;

    logic [PW-1:0]             r_ptr_bin;
    logic [PW-1:0]             r_ptr_gray;
    logic [PW-1:0]             r_level;
    logic                      r_empty;
    logic                      r_vld_p1;

    fifo_sync2 #(.WIDTH(PW)) u_wptr_sync (
        .i_clk   (rd_clk),
        .i_rst_n (rd_rst_n),
        .i_d     (bus.wr_ptr_gray),
        .o_q     (w_wq2)
    );

    // Flags are computed from the post-increment pointer so a pop and a
    // write-pointer advance landing on the same edge are both reflected.
    assign w_accept     = bus.rd_en && !r_empty;
    assign w_next_bin   = r_ptr_bin + PW'(w_accept);
    assign w_next_gray  = PW'(bin2gray(32'(w_next_bin)));
    assign w_next_level = PW'(gray2bin(32'(w_wq2))) - w_next_bin;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_ptr_bin  <= '0;
            r_ptr_gray <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_vld_p1   <= 1'b0;
        end else begin
            r_ptr_bin  <= w_next_bin;
            r_ptr_gray <= w_next_gray;
            r_level    <= w_next_level;
            r_empty    <= (w_next_gray == w_wq2);
            r_vld_p1   <= w_accept;
        end
    end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    logic r_almost_empty;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_empty <= (w_next_level <= AE_LVL);
        end
    end

    assign bus.rd_almost_empty = r_almost_empty;
`endif

    // Memory has one cycle of read latency, which lines up with r_vld_p1.
    assign w_rd_data       = bus.mem_rd_data;
    assign bus.rd_data     = w_rd_data;
    assign bus.rd_addr     = r_ptr_bin[FIFO_DEPTH_Bit-1:0];
    assign bus.rd_ptr_gray = r_ptr_gray;
    assign bus.rd_level    = r_level;
    assign bus.rd_empty    = r_empty;
    assign bus.rd_valid    = r_vld_p1;

endmodule
